// File: rtl/td4_run_ctrl_if.sv
// Board/core-side signal bundle for the TD4 execution controller.
//   master : drives buttons, halt_req (and breakpoint inputs), observes controller outputs
//   slave  : the controller itself
// Optional breakpoint signals exist only when TD4_CTRL_BKPT_EN is defined.
interface td4_run_ctrl_if;
    logic       run_btn;
    logic       step_btn;
    logic       halt_req;
    logic       cpu_ce;
    logic       cpu_rst;
    logic [1:0] state;
    logic [7:0] ce_count;
`ifdef TD4_CTRL_BKPT_EN
    logic       bkpt_en;
    logic [3:0] bkpt_addr;
    logic [3:0] pc;

    modport master (
        output run_btn, step_btn, halt_req, bkpt_en, bkpt_addr, pc,
        input  cpu_ce, cpu_rst, state, ce_count
    );
    modport slave (
        input  run_btn, step_btn, halt_req, bkpt_en, bkpt_addr, pc,
        output cpu_ce, cpu_rst, state, ce_count
    );
`else
    modport master (
        output run_btn, step_btn, halt_req,
        input  cpu_ce, cpu_rst, state, ce_count
    );
    modport slave (
        input  run_btn, step_btn, halt_req,
        output cpu_ce, cpu_rst, state, ce_count
    );
`endif
endinterface

// File: rtl/td4_run_ctrl.sv
// TD4 execution controller: turns the board clock and two push-buttons into a
// CPU clock-enable (cpu_ce) and a CPU reset (cpu_rst). Modes: HOLD (reset
// stretch), STOP, RUN (prescaled free-run), STEP (single cpu_ce pulse).
// Ports:
//   clock, reset      board clock, async active-high reset
//   io.run_btn/step_btn   raw asynchronous buttons
//   io.halt_req       stop request from the core
//   io.cpu_ce/cpu_rst core enable / reset (registered)
//   io.state          00 HOLD, 01 STOP, 10 RUN, 11 STEP
//   io.ce_count       number of cpu_ce pulses, mod 256
// Optional: define TD4_CTRL_BKPT_EN to add the pc breakpoint (io.bkpt_en,
// io.bkpt_addr, io.pc).
module td4_run_ctrl #(
    parameter int unsigned DIV        = 4,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned RST_HOLD   = 4
) (
    input  logic          clock,
    input  logic          reset,
    td4_run_ctrl_if.slave io
);
    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'b00,
        S_STOP = 2'b01,
        S_RUN  = 2'b10,
        S_STEP = 2'b11
    } state_t;

    // Button path: index 0 = run, index 1 = step
    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [1:0]    filt_q;
    logic [1:0]    pulse;
    logic [DW-1:0] deb_cnt [2];
    logic          run_p;
    logic          step_p;

    assign btn_raw = {io.step_btn, io.run_btn};
    assign run_p   = pulse[0];
    assign step_p  = pulse[1];

    // Synchronize, debounce and edge-detect both buttons
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            filt_q <= '0;
            pulse  <= '0;
            for (int b = 0; b < 2; b++) deb_cnt[b] <= '0;
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            filt_q <= filt;
            pulse  <= filt & ~filt_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == filt[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DW'(DEB_CYCLES - 1)) begin
                    filt[b]    <= sync2[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + DW'(1);
                end
            end
        end
    end

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          cpu_ce_q;
    logic          cpu_ce_d;
    logic          cpu_rst_q;
    logic          cpu_rst_d;
    logic [7:0]    ce_count_q;
    logic          wrap;
    logic          bkpt_hit;
    logic          stop_req;

    assign wrap = (presc_q == PW'(DIV - 1));

`ifdef TD4_CTRL_BKPT_EN
    // Breakpoint only matters on a cycle where cpu_ce would fire
    assign bkpt_hit = wrap & io.bkpt_en & (io.pc == io.bkpt_addr);
`else
    assign bkpt_hit = 1'b0;
`endif

    assign stop_req = io.halt_req | run_p | bkpt_hit;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_HOLD;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD: if (hold_q == HW'(RST_HOLD - 1)) state_d = S_STOP;
            S_STOP: begin
                if (run_p)       state_d = S_RUN;
                else if (step_p) state_d = S_STEP;
            end
            S_RUN:  if (stop_req) state_d = S_STOP;
            S_STEP: state_d = S_STOP;
            default: state_d = S_HOLD;
        endcase
    end

    // Output logic: next values of the registered outputs and counters
    always_comb begin
        cpu_ce_d  = 1'b0;
        cpu_rst_d = (state_d == S_HOLD);
        presc_d   = '0;
        hold_d    = hold_q;
        case (state_q)
            S_HOLD: hold_d = hold_q + HW'(1);
            // The single step pulse is issued on entry so it coincides with STEP
            S_STOP: cpu_ce_d = (state_d == S_STEP);
            S_RUN: begin
                cpu_ce_d = wrap & ~stop_req;
                if (state_d == S_RUN) presc_d = wrap ? '0 : presc_q + PW'(1);
            end
            default: ;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_ce_q   <= 1'b0;
            cpu_rst_q  <= 1'b1;
            ce_count_q <= '0;
            presc_q    <= '0;
            hold_q     <= '0;
        end else begin
            cpu_ce_q   <= cpu_ce_d;
            cpu_rst_q  <= cpu_rst_d;
            ce_count_q <= ce_count_q + {7'd0, cpu_ce_q};
            presc_q    <= presc_d;
            hold_q     <= hold_d;
        end
    end

    assign io.cpu_ce   = cpu_ce_q;
    assign io.cpu_rst  = cpu_rst_q;
    assign io.state    = state_q;
    assign io.ce_count = ce_count_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Bench for td4_run_ctrl: directed scenarios plus randomized button/halt
// traffic, compared every cycle against a behavioural model built from the
// mode rules (raw-sample history for debounce, edge arithmetic for RUN).
module tb_td4_run_ctrl;
    localparam int DIV  = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 4;
    localparam int M_HOLD = 0;
    localparam int M_STOP = 1;
    localparam int M_RUN  = 2;
    localparam int M_STEP = 3;
    localparam int HDEPTH = 16384;

    logic clock = 1'b0;
    logic reset = 1'b0;

    td4_run_ctrl_if io();

    td4_run_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .RST_HOLD(HOLD)) dut (
        .clock(clock),
        .reset(reset),
        .io(io)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   n;                         // edges since reset release
    bit   raw_h  [2][HDEPTH];        // raw button sampled at edge e
    bit   rise_h [2][HDEPTH];        // filtered level rose at edge e
    bit   filt   [2];
    int   mode;
    int   enter;
    logic m_ce;
    int   m_cnt;

    function automatic bit raw_at(input int b, input int e);
        if (e < 1) return 1'b0;
        return raw_h[b][e];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            n = 0; filt[0] = 1'b0; filt[1] = 1'b0;
            mode = M_HOLD; enter = 0; m_ce = 1'b0; m_cnt = 0;
        end else begin
            bit btn_p [2];
            bit all_diff, fire, stop, bk;
            logic ce_nxt;
            n++;
            if (n >= HDEPTH) begin
                $display("FAIL model_depth: got %0d expected below %0d", n, HDEPTH);
                $fatal(1);
            end
            raw_h[0][n] = io.run_btn;
            raw_h[1][n] = io.step_btn;
            for (int b = 0; b < 2; b++) begin
                // Level flips once the last DEB synchronized samples all disagree
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (raw_at(b, n - 2 - j) == filt[b]) all_diff = 1'b0;
                rise_h[b][n] = all_diff & ~filt[b];
                if (all_diff) filt[b] = ~filt[b];
                btn_p[b] = (n >= 3) ? rise_h[b][n - 2] : 1'b0;
            end
            m_cnt = (m_cnt + 32'(m_ce)) % 256;
            bk = 1'b0;
`ifdef TD4_CTRL_BKPT_EN
            bk = io.bkpt_en && (io.pc == io.bkpt_addr);
`endif
            ce_nxt = 1'b0;
            case (mode)
                M_HOLD: if (n == HOLD) mode = M_STOP;
                M_STOP: begin
                    if (btn_p[0]) begin mode = M_RUN; enter = n; end
                    else if (btn_p[1]) begin mode = M_STEP; ce_nxt = 1'b1; end
                end
                M_RUN: begin
                    fire = ((n - enter) % DIV) == 0;
                    stop = io.halt_req || btn_p[0] || (fire && bk);
                    if (stop) mode = M_STOP;
                    else      ce_nxt = fire;
                end
                default: mode = M_STOP;
            endcase
            m_ce = ce_nxt;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (check_en) begin
            chk("cpu_ce",   32'(io.cpu_ce),   32'(m_ce));
            chk("cpu_rst",  32'(io.cpu_rst),  32'(mode == M_HOLD));
            chk("state",    32'(io.state),    32'(mode));
            chk("ce_count", 32'(io.ce_count), 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int pulses, ce_at, enter_i, t, t2, first, run_left, step_left, hit;
        io.run_btn  = 1'b0;
        io.step_btn = 1'b0;
        io.halt_req = 1'b0;
`ifdef TD4_CTRL_BKPT_EN
        io.bkpt_en   = 1'b0;
        io.bkpt_addr = 4'd0;
        io.pc        = 4'd0;
`endif
        #1 reset = 1'b1;
        check_en = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // T1: reset stretch
        chk("t1_state0",  32'(io.state),    32'd0);
        chk("t1_rst0",    32'(io.cpu_rst),  32'd1);
        chk("t1_count0",  32'(io.ce_count), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            chk("t1_rst",   32'(io.cpu_rst), (i < 4) ? 32'd1 : 32'd0);
            chk("t1_state", 32'(io.state),   (i < 4) ? 32'd0 : 32'd1);
        end

        // T2: single step, held 20 clocks
        io.step_btn = 1'b1; pulses = 0; ce_at = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (io.cpu_ce) begin pulses++; if (ce_at == 0) ce_at = i; end
            if (i == 8) chk("t2_state_step", 32'(io.state), 32'd3);
            if (i == 9) chk("t2_state_stop", 32'(io.state), 32'd1);
        end
        io.step_btn = 1'b0;
        repeat (10) @(negedge clock);
        chk("t2_pulses", 32'(pulses), 32'd1);
        chk("t2_ce_at",  32'(ce_at),  32'd8);
        chk("t2_count",  32'(io.ce_count), 32'd1);

        // T3: bouncing step button never settles
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            io.step_btn = (i % 2) == 1;
            @(negedge clock);
            if (io.cpu_ce) pulses++;
        end
        io.step_btn = 1'b0;
        repeat (10) @(negedge clock);
        chk("t3_pulses", 32'(pulses), 32'd0);
        chk("t3_state",  32'(io.state), 32'd1);
        chk("t3_count",  32'(io.ce_count), 32'd1);

        // T4: run for 40 clocks, then stop
        io.run_btn = 1'b1; pulses = 0; enter_i = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (i == 10) io.run_btn = 1'b0;
            if (enter_i == 0 && io.state == 2'd2) enter_i = i;
            else if (enter_i != 0 && i <= enter_i + 40 && io.cpu_ce) pulses++;
        end
        chk("t4_enter",  32'(enter_i), 32'd8);
        chk("t4_pulses", 32'(pulses),  32'd10);
        io.run_btn = 1'b1; t = 0;
        while (io.state != 2'd1 && t < 30) begin
            @(negedge clock); t++;
            if (t == 10) io.run_btn = 1'b0;
        end
        chk("t4_stop_latency", 32'(t), 32'd8);
        repeat (15) @(negedge clock);
        io.run_btn = 1'b0;
        repeat (10) @(negedge clock);

        // T5: halt on the wrap cycle, then step past the halt
        io.run_btn = 1'b1; t = 0; enter_i = 0;
        while (enter_i == 0 && t < 30) begin
            @(negedge clock); t++;
            if (t == 10) io.run_btn = 1'b0;
            if (io.state == 2'd2) enter_i = t;
        end
        chk("t5_enter", 32'(enter_i), 32'd8);
        t2 = 0; first = 0;
        while (first == 0 && t2 < 20) begin
            @(negedge clock); t++; t2++;
            if (t == 10) io.run_btn = 1'b0;
            if (io.cpu_ce) first = t2;
        end
        chk("t5_first_ce", 32'(first), 32'd4);
        io.run_btn = 1'b0;
        repeat (3) @(negedge clock);
        io.halt_req = 1'b1;
        @(negedge clock);
        chk("t5_halt_ce",    32'(io.cpu_ce), 32'd0);
        chk("t5_halt_state", 32'(io.state),  32'd1);
        io.step_btn = 1'b1; pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (io.cpu_ce) pulses++;
        end
        io.step_btn = 1'b0;
        repeat (10) @(negedge clock);
        io.halt_req = 1'b0;
        chk("t5_step_pulses", 32'(pulses), 32'd1);

        // Randomized traffic
        run_left = 0; step_left = 0;
        for (int c = 0; c < 800; c++) begin
            if (run_left > 0) run_left--;
            else if ($urandom_range(0, 30) == 0) run_left = $urandom_range(1, 12);
            if (step_left > 0) step_left--;
            else if ($urandom_range(0, 30) == 0) step_left = $urandom_range(1, 12);
            io.run_btn  = (run_left > 0);
            io.step_btn = (step_left > 0) ^ ($urandom_range(0, 15) == 0);
            io.halt_req = ($urandom_range(0, 19) == 0);
`ifdef TD4_CTRL_BKPT_EN
            io.bkpt_en   = 1'($urandom_range(0, 1));
            io.bkpt_addr = 4'($urandom_range(0, 3));
            io.pc        = 4'($urandom_range(0, 3));
`endif
            @(negedge clock);
        end
        io.run_btn = 1'b0; io.step_btn = 1'b0; io.halt_req = 1'b0;
`ifdef TD4_CTRL_BKPT_EN
        io.bkpt_en = 1'b0;
`endif
        repeat (12) @(negedge clock);
        io.halt_req = 1'b1;
        repeat (2) @(negedge clock);
        io.halt_req = 1'b0;
        repeat (2) @(negedge clock);
        chk("rand_settled_stop", 32'(io.state), 32'd1);

        // T6: ce_count wrap, then asynchronous reset mid-RUN
        io.run_btn = 1'b1; t = 0;
        while (io.ce_count != 8'd255 && t < 3000) begin
            @(negedge clock); t++;
            if (t == 10) io.run_btn = 1'b0;
        end
        io.run_btn = 1'b0;
        chk("t6_reach_255", 32'(io.ce_count), 32'd255);
        t = 0; hit = 0;
        while (hit == 0 && t < 20) begin
            @(negedge clock); t++;
            if (io.cpu_ce) hit = 1;
        end
        chk("t6_next_pulse", 32'(hit), 32'd1);
        @(negedge clock);
        chk("t6_wrap", 32'(io.ce_count), 32'd0);
        chk("t6_in_run", 32'(io.state), 32'd2);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("t6_async_state", 32'(io.state),    32'd0);
        chk("t6_async_rst",   32'(io.cpu_rst),  32'd1);
        chk("t6_async_ce",    32'(io.cpu_ce),   32'd0);
        chk("t6_async_count", 32'(io.ce_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/td4_run_ctrl.md
Name: td4_run_ctrl

Overview:
Execution controller for the TD4 4-bit CPU core. Turns the board clock and two push-buttons into a CPU clock-enable and a CPU reset. Supports free-run at a prescaled rate, single-step, and halt on request from the core. Sits between the board inputs and the core inside the top level; the core is clocked by the board clock and advances only when cpu_ce is high.

Parameters:
DIV, 4, prescaler ratio in RUN; one cpu_ce pulse every DIV clocks (legal 2..256).
DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (legal 1..65535).
RST_HOLD, 4, clocks cpu_rst stays asserted after reset release (legal 1..255).

Ports:
clock  in  1  board clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset of the whole block.
run_btn  in  1  raw run/stop button, asynchronous, active-high.
step_btn  in  1  raw single-step button, asynchronous, active-high.
halt_req  in  1  from core, synchronous to clock; requests stop (e.g. HLT / jump-to-self detected).
cpu_ce  out  1  CPU clock-enable; one-cycle pulses.
cpu_rst  out  1  synchronous reset to core, active-high.
state  out  2  current FSM state: 00 HOLD, 01 STOP, 10 RUN, 11 STEP.
ce_count  out  8  number of cpu_ce pulses issued; wraps 255->0.

Behaviour:
- Reset asserted, asynchronous: state=HOLD, cpu_rst=1, cpu_ce=0, ce_count=0, prescaler=0, debouncers cleared to 0. The same applies when reset is asserted mid-operation.
- Button path, per button:
  - 2-FF synchronizer.
  - Debounce counter: the filtered level changes only after DEB_CYCLES consecutive samples that differ from the current filtered level; any matching sample clears the counter.
  - Rising edge of the filtered level gives a one-cycle pulse (run_p, step_p).
  - Latency from the first stable raw high to the pulse is 2+DEB_CYCLES+1 clocks.
  - Releases are debounced identically but produce no pulse.
- HOLD:
  - cpu_rst=1. Counts RST_HOLD clocks after reset deasserts, then goes to STOP.
  - cpu_rst falls on the same edge as the transition.
  - Button pulses are ignored while in HOLD.
- STOP:
  - cpu_ce=0, prescaler held at 0.
  - run_p -> RUN. step_p -> STEP.
  - run_p and step_p in the same cycle: run_p wins.
- RUN:
  - Prescaler counts 0..DIV-1 and wraps.
  - cpu_ce=1 in each cycle where prescaler==DIV-1. The first pulse comes DIV clocks after entering RUN.
  - halt_req=1 -> STOP on the next edge; cpu_ce is forced 0 in that cycle even if prescaler==DIV-1.
  - run_p -> STOP, with the same cpu_ce suppression.
  - step_p is ignored.
  - Leaving RUN resets the prescaler to 0.
- STEP:
  - cpu_ce=1 for exactly one cycle, then STOP unconditionally.
  - halt_req is ignored, so the core can be stepped past a halt.
  - Button pulses arriving during STEP are ignored.
- ce_count increments on every clock where cpu_ce=1, mod 256. Only reset clears it.
- cpu_ce and cpu_rst are never both 1.
- All outputs are registered.

Optional Feature:
TD4_CTRL_BKPT_EN:
- Defined: adds inputs bkpt_en (1 bit), bkpt_addr (4 bits) and pc (4 bits, from the core).
  - In RUN, if bkpt_en=1 and pc==bkpt_addr on a cycle where cpu_ce would fire, cpu_ce is suppressed and the next state is STOP.
  - STEP ignores the breakpoint, so single-stepping off a breakpoint works.
  - Priority in RUN: halt_req = run_p = breakpoint, all of which lead to STOP.
- Undefined: these ports and the logic do not exist; behaviour is exactly as above.

Test Plan:
1. Pulse reset high, release; DIV=4, DEB_CYCLES=4, RST_HOLD=4 -> cpu_rst=1 for 4 clocks after release; state 00 then 01; cpu_ce=0; ce_count=0.
2. In STOP, hold step_btn high 20 clocks -> exactly one cpu_ce pulse, 7 clocks after the first high sample; state goes 01->11->01; ce_count=1.
3. In STOP, toggle step_btn every clock for 30 clocks, then low -> no cpu_ce, state stays 01, ce_count unchanged.
4. Press run_btn (held 10 clocks), observe 40 clocks -> state=10, cpu_ce every 4th clock, 10 pulses. Press run again -> state=01 and prescaler cleared.
5. In RUN, drive halt_req=1 on the cycle prescaler==3 -> no cpu_ce that cycle, state=01 next clock. Then step -> one cpu_ce despite halt_req=1.
6. Let ce_count reach 255 in RUN, then one more pulse -> ce_count=0. Assert reset mid-RUN -> cpu_ce=0, cpu_rst=1, state=00 immediately (asynchronously), ce_count=0.
